// File: rtl/serial_arith_unit.sv
// Bit-serial arithmetic unit: pass, negate, increment or decrement a WIDTH-bit
// word streamed LSB first, with a Mealy result bit and a per-frame overflow flag.
module serial_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       valid,
  input  logic       x,
  output logic       z,
  output logic       z_valid,
  output logic       last,
  output logic       ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_INC  = 2'b10,
    MODE_DEC  = 2'b11
  } mode_t;

  state_t           r_state;
  state_t           w_state_next;
  mode_t            r_mode;
  mode_t            w_mode_eff;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_eff;
  logic             r_f;
  logic             w_f_eff;
  logic             w_f_next;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;
  logic             w_z_raw;
  logic             w_frame_ovf;

  // A start overrides the stored frame context for its own cycle, so the
  // first bit can ride on the start cycle and an open frame can be abandoned.
  always_comb begin
    w_mode_eff = start ? mode_t'(mode) : r_mode;
    w_cnt_eff  = start ? '0 : r_cnt;
    w_f_eff    = start ? mode[1] : r_f;
    w_accept   = valid && (start || (r_state == ST_ACTIVE));
    w_last     = w_accept && (w_cnt_eff == CNT_LAST);
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_z_raw     = x;
    w_f_next    = w_f_eff;
    w_frame_ovf = 1'b0;
    unique case (w_mode_eff)
      MODE_PASS: begin
        w_z_raw     = x;
        w_f_next    = w_f_eff;
        w_frame_ovf = 1'b0;
      end
      MODE_NEG: begin
        // Copy bits up to and including the first one, invert the rest.
        w_z_raw     = x ^ w_f_eff;
        w_f_next    = w_f_eff | x;
        w_frame_ovf = ~w_f_eff & x;
      end
      MODE_INC: begin
        w_z_raw     = x ^ w_f_eff;
        w_f_next    = x & w_f_eff;
        w_frame_ovf = x & w_f_eff;
      end
      MODE_DEC: begin
        w_z_raw     = x ^ w_f_eff;
        w_f_next    = ~x & w_f_eff;
        w_frame_ovf = ~x & w_f_eff;
      end
      default: begin
        w_z_raw     = x;
        w_f_next    = w_f_eff;
        w_frame_ovf = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // WIDTH >= 2 means a bit accepted on a start cycle can never be the last.
  always_comb begin
    w_state_next = r_state;
    if (w_last) begin
      w_state_next = ST_IDLE;
    end else if (start) begin
      w_state_next = ST_ACTIVE;
    end
  end

  always_comb begin
    z       = w_accept & w_z_raw;
    z_valid = w_accept;
    last    = w_last;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_mode <= MODE_PASS;
      r_cnt  <= '0;
      r_f    <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (start || w_accept) begin
        r_mode <= w_mode_eff;
        r_f    <= w_accept ? w_f_next : w_f_eff;
        if (w_last) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt <= w_cnt_eff + CNT_W'(1);
        end else begin
          r_cnt <= w_cnt_eff;
        end
      end
      // Aborted frames never reach the last bit, so ovf keeps its value.
      if (w_last) begin
        r_ovf <= w_frame_ovf;
      end
    end
  end

  assign ovf = r_ovf;

endmodule
